// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencer for the MIPS-subset datapath with memory ready handshake.
// Optional MULTICYCLE_ILLEGAL_TRAP_EN: illegal opcodes trap and hold instead of acting as a NOP.
module multicycle_control #(
  parameter int unsigned MAX_WAIT    = 15,
  parameter int unsigned INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_src,
  output logic                   ir_write,
  output logic                   i_or_d,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [INSTR_CNT_W-1:0] instr_retired,
  output logic                   bus_err,
  output logic                   trap
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  localparam logic [5:0] OpR     = 6'b000000;
  localparam logic [5:0] OpSubiu = 6'b001101;
  localparam logic [5:0] OpSw    = 6'b010000;
  localparam logic [5:0] OpLw    = 6'b010001;
  localparam logic [5:0] OpSlti  = 6'b101010;
  localparam logic [5:0] OpBeq   = 6'b010011;
  localparam logic [5:0] OpJ     = 6'b011100;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StMemAddr,
    StMemRd, StWbMem, StMemWr, StBranch, StJump, StIllegal, StErr
  } state_e;

  state_e                 state_q, state_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;
  logic                   bus_err_q, bus_err_d;
  logic                   wait_expired;

  // Counter is only kept while stalled in a memory state; every other path clears it.
  assign wait_expired = !mem_ready && (wait_q == WaitLast);

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    cnt_d         = cnt_q;
    bus_err_d     = bus_err_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d   = StErr;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpR:             state_d = StExecR;
          OpSubiu, OpSlti: state_d = StExecI;
          OpLw, OpSw:      state_d = StMemAddr;
          OpBeq:           state_d = StBranch;
          OpJ:             state_d = StJump;
          default:         state_d = StIllegal;
        endcase
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StWbR;
      end
      StWbR: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        cnt_d     = cnt_q + INSTR_CNT_W'(1);
        state_d   = StFetch;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OpSlti) ? 2'b11 : 2'b01;
        state_d   = StWbI;
      end
      StWbI: begin
        reg_write = 1'b1;
        cnt_d     = cnt_q + INSTR_CNT_W'(1);
        state_d   = StFetch;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          state_d = StWbMem;
        end else if (wait_expired) begin
          state_d   = StErr;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWbMem: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        cnt_d      = cnt_q + INSTR_CNT_W'(1);
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          cnt_d   = cnt_q + INSTR_CNT_W'(1);
          state_d = StFetch;
        end else if (wait_expired) begin
          state_d   = StErr;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        cnt_d         = cnt_q + INSTR_CNT_W'(1);
        state_d       = StFetch;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        cnt_d    = cnt_q + INSTR_CNT_W'(1);
        state_d  = StFetch;
      end
      StIllegal: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        state_d = StIllegal;
`else
        state_d = StFetch;
`endif
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instr_retired = cnt_q;
  assign bus_err       = bus_err_q;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;

  // Raised on the DECODE exit edge so trap is already visible in the ILLEGAL cycle.
  always_comb begin
    trap_d = trap_q | (state_d == StIllegal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, memory stalls, timeout,
// illegal opcode handling and asynchronous reset mid-access.
module tb_multicycle_control;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [5:0]  opcode    = 6'b000000;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_req, mem_we;
  logic        reg_dst, reg_write, mem_to_reg, alu_src_a, bus_err, trap;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [31:0] instr_retired;
  logic [15:0] strobes;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // {pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_req, mem_we,
  //  reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op}
  localparam logic [15:0] SZero     = 16'h0000;
  localparam logic [15:0] SFetchRdy = 16'h8A04;
  localparam logic [15:0] SFetchWt  = 16'h0204;
  localparam logic [15:0] SDecode   = 16'h000C;
  localparam logic [15:0] SExecR    = 16'h0012;
  localparam logic [15:0] SWbR      = 16'h00C0;
  localparam logic [15:0] SExecSub  = 16'h0019;
  localparam logic [15:0] SExecSlt  = 16'h001B;
  localparam logic [15:0] SWbI      = 16'h0040;
  localparam logic [15:0] SMemAddr  = 16'h0018;
  localparam logic [15:0] SMemRd    = 16'h0600;
  localparam logic [15:0] SWbMem    = 16'h0060;
  localparam logic [15:0] SMemWr    = 16'h0700;
  localparam logic [15:0] SBranch   = 16'h5011;
  localparam logic [15:0] SJump     = 16'hA000;

  localparam logic [5:0] OpR = 6'b000000, OpSubiu = 6'b001101, OpSw = 6'b010000;
  localparam logic [5:0] OpLw = 6'b010001, OpSlti = 6'b101010, OpBeq = 6'b010011;
  localparam logic [5:0] OpJ = 6'b011100, OpBad = 6'b111111;

  assign strobes = {pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_req, mem_we,
                    reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  multicycle_control #(
    .MAX_WAIT    (4),
    .INSTR_CNT_W (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_retired (instr_retired),
    .bus_err       (bus_err),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive mem_ready for the coming cycle at the falling edge, then check the strobes.
  task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check_eq(tag, 32'(strobes), 32'(exp));
  endtask

  task automatic run_reset(input logic [5:0] next_op);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_strobes", 32'(strobes), 32'(SZero));
    check_eq("rst_retired", instr_retired, 32'd0);
    check_eq("rst_bus_err", 32'(bus_err), 32'd0);
    check_eq("rst_trap", 32'(trap), 32'd0);
    @(negedge clk);
    check_eq("rst_hold", 32'(strobes), 32'(SZero));
    @(negedge clk);
    opcode = next_op;
    rst_n  = 1'b1;
    #1;
    check_eq("idle", 32'(strobes), 32'(SZero));
  endtask

  initial begin
    #2;
    run_reset(OpR);
    // R-type, zero wait
    cyc("r_fetch", 1'b1, SFetchRdy);
    cyc("r_dec", 1'b1, SDecode);
    cyc("r_exec", 1'b1, SExecR);
    cyc("r_wb", 1'b1, SWbR);
    check_eq("r_cnt_before", instr_retired, 32'd0);
    // LW with three stalled fetch cycles
    opcode = OpLw;
    cyc("lw_f1", 1'b0, SFetchWt);
    check_eq("lw_cnt", instr_retired, 32'd1);
    cyc("lw_f2", 1'b0, SFetchWt);
    cyc("lw_f3", 1'b0, SFetchWt);
    cyc("lw_f4", 1'b1, SFetchRdy);
    cyc("lw_dec", 1'b1, SDecode);
    cyc("lw_addr", 1'b1, SMemAddr);
    cyc("lw_rd", 1'b1, SMemRd);
    cyc("lw_wb", 1'b1, SWbMem);
    opcode = OpBeq;
    cyc("beq_f", 1'b1, SFetchRdy);
    check_eq("beq_cnt", instr_retired, 32'd2);
    cyc("beq_dec", 1'b1, SDecode);
    cyc("beq_br", 1'b1, SBranch);
    opcode = OpJ;
    cyc("j_f", 1'b1, SFetchRdy);
    check_eq("j_cnt", instr_retired, 32'd3);
    cyc("j_dec", 1'b1, SDecode);
    cyc("j_jmp", 1'b1, SJump);
    opcode = OpSubiu;
    cyc("subiu_f", 1'b1, SFetchRdy);
    check_eq("subiu_cnt", instr_retired, 32'd4);
    cyc("subiu_dec", 1'b1, SDecode);
    cyc("subiu_exec", 1'b1, SExecSub);
    cyc("subiu_wb", 1'b1, SWbI);
    opcode = OpSlti;
    cyc("slti_f", 1'b1, SFetchRdy);
    check_eq("slti_cnt", instr_retired, 32'd5);
    cyc("slti_dec", 1'b1, SDecode);
    cyc("slti_exec", 1'b1, SExecSlt);
    cyc("slti_wb", 1'b1, SWbI);
    opcode = OpBad;
    cyc("ill_f", 1'b1, SFetchRdy);
    check_eq("ill_cnt_pre", instr_retired, 32'd6);
    cyc("ill_dec", 1'b1, SDecode);
    cyc("ill_state", 1'b1, SZero);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    check_eq("trap_set", 32'(trap), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc("trap_hold", 1'b1, SZero);
      check_eq("trap_sticky", 32'(trap), 32'd1);
    end
`else
    check_eq("trap_tied", 32'(trap), 32'd0);
    cyc("ill_next_fetch", 1'b1, SFetchRdy);
`endif
    check_eq("ill_cnt_post", instr_retired, 32'd6);
    run_reset(OpR);
    cyc("r2_fetch", 1'b1, SFetchRdy);
    cyc("r2_dec", 1'b1, SDecode);
    cyc("r2_exec", 1'b1, SExecR);
    cyc("r2_wb", 1'b1, SWbR);
    // SW zero wait retires on the MEM_WR exit edge
    opcode = OpSw;
    cyc("sw_f", 1'b1, SFetchRdy);
    check_eq("sw_cnt_pre", instr_retired, 32'd1);
    cyc("sw_dec", 1'b1, SDecode);
    cyc("sw_addr", 1'b1, SMemAddr);
    cyc("sw_wr", 1'b1, SMemWr);
    cyc("sw2_f", 1'b1, SFetchRdy);
    check_eq("sw_cnt_post", instr_retired, 32'd2);
    cyc("sw2_dec", 1'b1, SDecode);
    cyc("sw2_addr", 1'b1, SMemAddr);
    cyc("sw2_wr", 1'b0, SMemWr);
    // Asynchronous reset in the middle of a stalled write
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_strobes", 32'(strobes), 32'(SZero));
    check_eq("midrst_retired", instr_retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_idle", 32'(strobes), 32'(SZero));
    cyc("midrst_fetch", 1'b1, SFetchRdy);
    // SW with mem_ready stuck low: MAX_WAIT=4 stall cycles then ERR
    cyc("to_dec", 1'b1, SDecode);
    cyc("to_addr", 1'b1, SMemAddr);
    for (int i = 0; i < 4; i++) begin
      cyc("to_wr_wait", 1'b0, SMemWr);
      check_eq("to_no_err_yet", 32'(bus_err), 32'd0);
    end
    for (int i = 0; i < 20; i++) begin
      cyc("err_strobes", i[0], SZero);
      check_eq("err_sticky", 32'(bus_err), 32'd1);
    end
    check_eq("err_cnt", instr_retired, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
